// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator.
// Holds the fetch PC and offers it to the I-cache through a valid/ready
// handshake. The PC advances by the byte count decode consumed. Exception
// and branch redirects are applied one edge after they are flagged, even
// while the front end is stalled. WFI puts the block to sleep until the CSR
// wake flag or an exception arrives. A branch that coincides with the wake
// flag is parked in a one-entry pending register. That entry is applied on
// the first cycle after sleep.
module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Ctrl_Stall_If,
    input  logic                  EX_BranchFlag,
    input  logic [ADDR_WIDTH-1:0] EX_BranchPC,
    input  logic                  Csr_ExcpFlag,
    input  logic [ADDR_WIDTH-1:0] Csr_ExcpPC,
    input  logic                  Decode_WfiFlag,
    input  logic                  Csr_WFIClrFlag,
    input  logic [3:0]            Decode_Advance,
    input  logic                  Icache_Ready,
    output logic                  Fetch_Valid,
    output logic [ADDR_WIDTH-1:0] Fetch_PC,
    output logic                  Redirect_Pulse,
    output logic                  Advance_Err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        SLEEP = 2'd3
    } state_t;

    state_t                  stateReg;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   pcNext;
    logic                    validNext;
    logic                    pulseNext;
    logic                    errNext;

    // One-entry pending redirect.
    logic                    pendVld;
    logic [ADDR_WIDTH-1:0]   pendPc;
    logic                    pendExcp;
    logic                    pendVldNext;
    logic [ADDR_WIDTH-1:0]   pendPcNext;
    logic                    pendExcpNext;

    // Redirect selected for this cycle, merged from live flags and the pending entry.
    logic                    redirHit;
    logic [ADDR_WIDTH-1:0]   redirTgt;

    logic                    accept;
    logic [3:0]              advEven;
    logic [3:0]              advClean;
    logic                    advIllegal;

    // Advance decode. Odd values lose bit 0. Anything above 8 saturates to 8.
    always_comb begin
        advEven    = {Decode_Advance[3:1], 1'b0};
        advClean   = (advEven > 4'd8) ? 4'd8 : advEven;
        advIllegal = Decode_Advance[0] | (Decode_Advance > 4'd8);
        accept     = Fetch_Valid & Icache_Ready & ~Ctrl_Stall_If;
    end

    // Redirect priority:
    //   1. live exception
    //   2. pending exception
    //   3. live branch
    //   4. pending branch
    always_comb begin
        redirHit = 1'b0;
        redirTgt = Fetch_PC;
        if (Csr_ExcpFlag) begin
            redirHit = 1'b1;
            redirTgt = Csr_ExcpPC;
        end else if (pendVld && pendExcp) begin
            redirHit = 1'b1;
            redirTgt = pendPc;
        end else if (EX_BranchFlag) begin
            redirHit = 1'b1;
            redirTgt = EX_BranchPC;
        end else if (pendVld) begin
            redirHit = 1'b1;
            redirTgt = pendPc;
        end
    end

    // Next-state, next-PC and pending-register logic.
    always_comb begin
        stateNext    = stateReg;
        pcNext       = Fetch_PC;
        pulseNext    = 1'b0;
        errNext      = Advance_Err;
        pendVldNext  = pendVld;
        pendPcNext   = pendPc;
        pendExcpNext = pendExcp;

        case (stateReg)
            BOOT, RUN, HOLD: begin
                if (redirHit) begin
                    // A redirect ignores stall and ready.
                    // It also consumes or overrides any pending entry.
                    pcNext       = {redirTgt[ADDR_WIDTH-1:1], 1'b0};
                    pulseNext    = 1'b1;
                    stateNext    = RUN;
                    pendVldNext  = 1'b0;
                    pendExcpNext = 1'b0;
                end else if (stateReg == BOOT) begin
                    stateNext = RUN;
                end else if (Decode_WfiFlag) begin
                    stateNext = SLEEP;
                end else if (accept) begin
                    pcNext    = Fetch_PC + {{(ADDR_WIDTH-4){1'b0}}, advClean};
                    errNext   = Advance_Err | advIllegal;
                    stateNext = RUN;
                end else begin
                    stateNext = HOLD;
                end
            end
            SLEEP: begin
                if (Csr_ExcpFlag) begin
                    pcNext    = {Csr_ExcpPC[ADDR_WIDTH-1:1], 1'b0};
                    pulseNext = 1'b1;
                    stateNext = RUN;
                end else if (Csr_WFIClrFlag) begin
                    stateNext = RUN;
                    if (EX_BranchFlag) begin
                        pendVldNext  = 1'b1;
                        pendPcNext   = {EX_BranchPC[ADDR_WIDTH-1:1], 1'b0};
                        pendExcpNext = 1'b0;
                    end
                end
            end
            default: stateNext = BOOT;
        endcase

        validNext = (stateNext == RUN) || (stateNext == HOLD);
    end

    // Register all state and outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg       <= BOOT;
            Fetch_Valid    <= 1'b0;
            Fetch_PC       <= {RESET_PC[ADDR_WIDTH-1:1], 1'b0};
            Redirect_Pulse <= 1'b0;
            Advance_Err    <= 1'b0;
            pendVld        <= 1'b0;
            pendPc         <= '0;
            pendExcp       <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            Fetch_Valid    <= validNext;
            Fetch_PC       <= pcNext;
            Redirect_Pulse <= pulseNext;
            Advance_Err    <= errNext;
            pendVld        <= pendVldNext;
            pendPc         <= pendPcNext;
            pendExcp       <= pendExcpNext;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen.
// Each step drives one cycle of inputs and pushes the expected outputs
// onto a scoreboard queue. It pops that entry after the edge and compares.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        Ctrl_Stall_If;
    logic        EX_BranchFlag;
    logic [31:0] EX_BranchPC;
    logic        Csr_ExcpFlag;
    logic [31:0] Csr_ExcpPC;
    logic        Decode_WfiFlag;
    logic        Csr_WFIClrFlag;
    logic [3:0]  Decode_Advance;
    logic        Icache_Ready;
    logic        Fetch_Valid;
    logic [31:0] Fetch_PC;
    logic        Redirect_Pulse;
    logic        Advance_Err;

    fetch_pc_gen #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Ctrl_Stall_If (Ctrl_Stall_If),
        .EX_BranchFlag (EX_BranchFlag),
        .EX_BranchPC   (EX_BranchPC),
        .Csr_ExcpFlag  (Csr_ExcpFlag),
        .Csr_ExcpPC    (Csr_ExcpPC),
        .Decode_WfiFlag(Decode_WfiFlag),
        .Csr_WFIClrFlag(Csr_WFIClrFlag),
        .Decode_Advance(Decode_Advance),
        .Icache_Ready  (Icache_Ready),
        .Fetch_Valid   (Fetch_Valid),
        .Fetch_PC      (Fetch_PC),
        .Redirect_Pulse(Redirect_Pulse),
        .Advance_Err   (Advance_Err)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        pulse;
        logic        err;
    } expT;

    expT expQ[$];
    int  vecCnt = 0;
    int  errCnt = 0;
    int  stepNum = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecCnt++;
        if (got !== want) begin
            errCnt++;
            $display("FAIL step %0d %s: got %h expected %h", stepNum, tag, got, want);
        end
    endtask

    // Drive one cycle and queue the expected registered outputs after the edge.
    task automatic step(input logic rstN, input logic stall, input logic rdy,
                        input logic [3:0] adv,
                        input logic br, input logic [31:0] brPc,
                        input logic ex, input logic [31:0] exPc,
                        input logic wfi, input logic wake,
                        input logic eV, input logic [31:0] ePc,
                        input logic ePu, input logic eEr);
        expT e;
        expT o;
        @(negedge clk);
        rst_n          = rstN;
        Ctrl_Stall_If  = stall;
        Icache_Ready   = rdy;
        Decode_Advance = adv;
        EX_BranchFlag  = br;
        EX_BranchPC    = brPc;
        Csr_ExcpFlag   = ex;
        Csr_ExcpPC     = exPc;
        Decode_WfiFlag = wfi;
        Csr_WFIClrFlag = wake;
        e.valid = eV;
        e.pc    = ePc;
        e.pulse = ePu;
        e.err   = eEr;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        stepNum++;
        if (expQ.size() == 0) begin
            checkVal("queue", 32'd0, 32'd1);
        end else begin
            o = expQ.pop_front();
            checkVal("valid", {31'd0, Fetch_Valid},    {31'd0, o.valid});
            checkVal("pc",    Fetch_PC,                o.pc);
            checkVal("pulse", {31'd0, Redirect_Pulse}, {31'd0, o.pulse});
            checkVal("err",   {31'd0, Advance_Err},    {31'd0, o.err});
        end
        $display("step %0d: rst_n=%b stall=%b rdy=%b adv=%0d br=%b ex=%b wfi=%b wake=%b -> valid=%b pc=%h pulse=%b err=%b",
                 stepNum, rstN, stall, rdy, adv, br, ex, wfi, wake,
                 Fetch_Valid, Fetch_PC, Redirect_Pulse, Advance_Err);
    endtask

    initial begin
        rst_n = 1'b0; Ctrl_Stall_If = 1'b0; Icache_Ready = 1'b1; Decode_Advance = 4'd8;
        EX_BranchFlag = 1'b0; EX_BranchPC = '0; Csr_ExcpFlag = 1'b0; Csr_ExcpPC = '0;
        Decode_WfiFlag = 1'b0; Csr_WFIClrFlag = 1'b0;

        // Columns:
        //   rst stall rdy adv | br brPc | ex exPc | wfi wake
        //   | expected: valid pc pulse err
        // Reset, then the BOOT bubble, then sequential fetch.
        step(0,0,1,8, 0,0, 0,0, 0,0,  0,32'h8000_0000,0,0);
        step(0,0,1,8, 0,0, 0,0, 0,0,  0,32'h8000_0000,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0000,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0008,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0010,0,0);
        // Stall for three cycles, then resume.
        step(1,1,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0010,0,0);
        step(1,1,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0010,0,0);
        step(1,1,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0010,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0018,0,0);
        // Ready low holds the PC.
        step(1,0,0,8, 0,0, 0,0, 0,0,  1,32'h8000_0018,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0020,0,0);
        // Branch during stall, then exception wins over a coincident branch.
        step(1,1,1,8, 1,32'h8000_0100, 0,0, 0,0,  1,32'h8000_0100,1,0);
        step(1,1,1,8, 1,32'h8000_0500, 1,32'h8000_0200, 0,0,  1,32'h8000_0200,1,0);
        step(1,1,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0200,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0208,0,0);
        // Odd branch target has bit 0 cleared.
        step(1,0,1,8, 1,32'h8000_0041, 0,0, 0,0,  1,32'h8000_0040,1,0);
        // WFI, an ignored branch in sleep, then wake at the frozen PC.
        step(1,0,1,8, 0,0, 0,0, 1,0,  0,32'h8000_0040,0,0);
        step(1,0,1,8, 1,32'h8000_0900, 0,0, 0,0,  0,32'h8000_0040,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  0,32'h8000_0040,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,1,  1,32'h8000_0040,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0048,0,0);
        // Exception coincident with wake.
        step(1,0,1,8, 0,0, 0,0, 1,0,  0,32'h8000_0048,0,0);
        step(1,0,1,8, 0,0, 1,32'h8000_0300, 0,1,  1,32'h8000_0300,1,0);
        // Advances of 4, 6, 2 and 0.
        step(1,0,1,4, 0,0, 0,0, 0,0,  1,32'h8000_0304,0,0);
        step(1,0,1,6, 0,0, 0,0, 0,0,  1,32'h8000_030A,0,0);
        step(1,0,1,2, 0,0, 0,0, 0,0,  1,32'h8000_030C,0,0);
        step(1,0,1,0, 0,0, 0,0, 0,0,  1,32'h8000_030C,0,0);
        // Branch coincident with wake is parked.
        // It is applied on the next cycle, despite the stall.
        step(1,0,1,8, 0,0, 0,0, 1,0,  0,32'h8000_030C,0,0);
        step(1,0,1,8, 1,32'h8000_0700, 0,0, 0,1,  1,32'h8000_030C,0,0);
        step(1,1,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0700,1,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0708,0,0);
        // Address wrap, then illegal advances: 3 -> 2, 15 -> 8, 9 -> 8.
        step(1,0,1,8, 1,32'hFFFF_FFF8, 0,0, 0,0,  1,32'hFFFF_FFF8,1,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h0000_0000,0,0);
        step(1,0,1,3, 0,0, 0,0, 0,0,  1,32'h0000_0002,0,1);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h0000_000A,0,1);
        step(1,0,1,15,0,0, 0,0, 0,0,  1,32'h0000_0012,0,1);
        step(1,0,1,9, 0,0, 0,0, 0,0,  1,32'h0000_001A,0,1);
        // Reset while asleep clears everything, including the sticky error.
        step(1,0,1,8, 0,0, 0,0, 1,0,  0,32'h0000_001A,0,1);
        step(0,0,1,8, 0,0, 0,0, 0,0,  0,32'h8000_0000,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0000,0,0);
        // Reset in the cycle a pending branch would be written: nothing survives.
        step(1,0,1,8, 0,0, 0,0, 1,0,  0,32'h8000_0000,0,0);
        step(0,0,1,8, 1,32'h8000_0700, 0,0, 0,1,  0,32'h8000_0000,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0000,0,0);
        step(1,0,1,8, 0,0, 0,0, 0,0,  1,32'h8000_0008,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage PC generator directly upstream of the pipeline controller. It holds the fetch PC and presents it to the I-cache with a valid/ready handshake. It advances the PC by the byte count decode consumed, and applies exception and branch redirects, including redirects that arrive while the front end is stalled. It sleeps on WFI until the CSR wake flag. It consumes the controller's `Ctrl_Stall[0]`, `EX_BranchFlag`/`EX_BranchPC`, `Csr_ExcpFlag` and `Csr_WFIClrFlag`.

## Interface
- `ADDR_WIDTH`, 32, fetch address width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `Ctrl_Stall_If` in 1: controller `Ctrl_Stall[0]`; 1 = hold IF
- `EX_BranchFlag` in 1: resolved taken branch/jump redirect
- `EX_BranchPC` in ADDR_WIDTH: branch target
- `Csr_ExcpFlag` in 1: trap/xret redirect
- `Csr_ExcpPC` in ADDR_WIDTH: trap vector / return PC
- `Decode_WfiFlag` in 1: WFI decoded, enter sleep
- `Csr_WFIClrFlag` in 1: wake from sleep
- `Decode_Advance` in 4: bytes consumed by decode this cycle; legal values 0, 2, 4, 6, 8
- `Icache_Ready` in 1: I-cache accepts request
- `Fetch_Valid` out 1: request valid
- `Fetch_PC` out ADDR_WIDTH: request address, bit 0 always 0
- `Redirect_Pulse` out 1: one-cycle pulse when a redirect is applied to `Fetch_PC`
- `Advance_Err` out 1: sticky; illegal `Decode_Advance` seen

## Operation
- States:
  - `BOOT`: entered on reset; one cycle, no request.
  - `RUN`: normal fetch.
  - `HOLD`: stalled, or handshake not accepted.
  - `SLEEP`: WFI.
- `BOOT`→`RUN` unconditionally on the next cycle.
- `RUN`:
  - Request accepted when `Fetch_Valid & Icache_Ready & !Ctrl_Stall_If`.
  - On acceptance, `Fetch_PC <= Fetch_PC + Decode_Advance`.
  - If not accepted, go to `HOLD` with `Fetch_PC` unchanged.
- `HOLD`→`RUN` when stall is released and ready is high; the held PC is re-presented unchanged.
- Redirect priority, highest first: `Csr_ExcpFlag`, `EX_BranchFlag`, advance.
  - Redirect target: `Csr_ExcpPC` or `EX_BranchPC`, with bit 0 cleared.
  - Redirect is applied the next cycle regardless of `Ctrl_Stall_If` and `Icache_Ready`.
  - A redirect sets `Redirect_Pulse` and takes the FSM to `RUN`.
- Pending redirect register (`pend_vld`, `pend_pc`, `pend_excp`):
  - Written only when a redirect coincides with `Csr_WFIClrFlag` while in `SLEEP`.
  - Applied on the next non-`SLEEP` cycle.
  - An exception overwrites a pending branch; a branch never overwrites a pending exception.
- `Decode_WfiFlag` in `RUN`/`HOLD` (with no redirect in the same cycle): go to `SLEEP`, `Fetch_Valid=0`, `Fetch_PC` frozen at its current value.
- `SLEEP`:
  - Branch redirect is ignored.
  - `Csr_ExcpFlag` wakes the block: go to `RUN` at `Csr_ExcpPC`.
  - `Csr_WFIClrFlag` goes to `RUN` at the frozen PC.
  - Wake and exception in the same cycle: exception target wins.
- Arithmetic: PC add is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH; wrap from 32'hFFFF_FFF8 + 8 gives 0 with no flag.
- Illegal `Decode_Advance` (odd, or >8):
  - `Advance_Err` is set sticky until reset.
  - The PC advances by the value with bit 0 cleared, saturated to 8.

## Timing
- All outputs are registered.
- Values in reset: `Fetch_Valid=0`, `Fetch_PC=RESET_PC`, `Redirect_Pulse=0`, `Advance_Err=0`, state=`BOOT`, `pend_vld=0`.
- First cycle after `rst_n` rises: `BOOT`, `Fetch_Valid=0`. Next cycle: `Fetch_Valid=1`, `Fetch_PC=RESET_PC`.
- Redirect latency: flag sampled at edge N, new `Fetch_PC` and `Redirect_Pulse=1` visible after edge N, no bubble.
- Advance latency: accept at edge N, next PC after edge N.
- `Fetch_Valid`: stays high in `RUN`/`HOLD`; `Fetch_PC` is stable while valid and not accepted.
- Sleep timing:
  - WFI at edge N: `Fetch_Valid=0` after edge N.
  - Wake at edge M: `Fetch_Valid=1` after edge M.
- Reset asserted mid-operation (any state, including a pending redirect) returns to the reset values at the next edge.

## Test plan
- Reset release with ready=1, advance=8, no stall → `Fetch_PC` sequence 8000_0000, 8000_0008, 8000_0010; `Fetch_Valid` low for exactly one cycle after reset.
- `Ctrl_Stall_If=1` for 3 cycles at PC 8000_0010 → PC held for 3 cycles; resumes to 8000_0018 one cycle after stall drops.
- Branch to 8000_0100 during stall, then exception to 8000_0200 in the same cycle as another branch → `Fetch_PC`=8000_0100 with pulse, then 8000_0200 with pulse; ignored branch has no effect.
- WFI at PC 8000_0040, branch in `SLEEP`, then `Csr_WFIClrFlag` → valid low throughout sleep; resume at 8000_0040; no `Redirect_Pulse` from the ignored branch.
- Exception (vector 8000_0300) coincident with `Csr_WFIClrFlag` in `SLEEP` → resume at 8000_0300 with pulse.
- PC FFFF_FFF8 with advance=8 → 0000_0000. Then advance=3 → `Advance_Err=1` sticky, PC +2.
